// File: rtl/cache_meta_if.sv
// Request/response bundle between a cache controller and its valid/dirty/LRU metadata array.
interface cache_meta_if;
  logic [63:0] set_oh;
  logic        upd_en;
  logic        upd_way;
  logic        upd_valid;
  logic        upd_dirty;
  logic        touch_en;
  logic        touch_way;
  logic        flush_req;
  logic [1:0]  valid_out;
  logic [1:0]  dirty_out;
  logic        lru_out;
  logic        flush_busy;
  logic        flush_done;
  logic        oh_err;

  modport master (
    output set_oh, upd_en, upd_way, upd_valid, upd_dirty, touch_en, touch_way, flush_req,
    input  valid_out, dirty_out, lru_out, flush_busy, flush_done, oh_err
  );

  modport slave (
    input  set_oh, upd_en, upd_way, upd_valid, upd_dirty, touch_en, touch_way, flush_req,
    output valid_out, dirty_out, lru_out, flush_busy, flush_done, oh_err
  );
endinterface

// File: rtl/cache_meta_array.sv
// 64-set x 2-way valid/dirty store with per-set LRU bit and a sequential flush engine.
// Optional CACHE_META_ONEHOT_CHK_EN: flag and suppress writes when set_oh is not one-hot.
module cache_meta_array (
  input  logic         clk,
  input  logic         rstn,
  cache_meta_if.slave  bus
);
  localparam int SETS = 64;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt;
  logic [1:0]       valid [SETS];
  logic [1:0]       dirty [SETS];
  logic [SETS-1:0]  lru;
  logic             wr_ok;
  logic [1:0]       rd_valid, rd_dirty;
  logic             rd_lru;

`ifdef CACHE_META_ONEHOT_CHK_EN
  logic req_any, oh_bad;
  assign req_any    = bus.upd_en | bus.touch_en;
  assign oh_bad     = (bus.set_oh == '0) || ((bus.set_oh & (bus.set_oh - 64'd1)) != '0);
  assign wr_ok      = ~oh_bad;
  // Reset gating keeps the flag low while the block is held in reset.
  assign bus.oh_err = rstn & req_any & oh_bad;
`else
  assign wr_ok      = 1'b1;
  assign bus.oh_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      cnt     <= (state_q == FLUSH) ? cnt + 6'd1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.flush_req) state_d = FLUSH;
      FLUSH:   if (cnt == 6'd63) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
      lru <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) begin
        if (state_q == FLUSH) begin
          if (cnt == 6'(s)) begin
            valid[s] <= '0;
            dirty[s] <= '0;
            lru[s]   <= 1'b0;
          end
        end else if (state_q == IDLE && wr_ok && bus.set_oh[s]) begin
          if (bus.upd_en) begin
            valid[s][bus.upd_way] <= bus.upd_valid;
            dirty[s][bus.upd_way] <= bus.upd_dirty;
          end
          if (bus.touch_en) lru[s] <= ~bus.touch_way;
        end
      end
    end
  end

  // AND-OR read mux over stored state; no bypass of same-cycle writes.
  always_comb begin
    rd_valid = '0;
    rd_dirty = '0;
    rd_lru   = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      rd_valid = rd_valid | ({2{bus.set_oh[s]}} & valid[s]);
      rd_dirty = rd_dirty | ({2{bus.set_oh[s]}} & dirty[s]);
      rd_lru   = rd_lru   | (bus.set_oh[s] & lru[s]);
    end
  end

  assign bus.flush_busy = (state_q != IDLE);
  assign bus.flush_done = (state_q == DONE);
  assign bus.valid_out  = bus.flush_busy ? 2'b00 : rd_valid;
  assign bus.dirty_out  = rd_dirty;
  assign bus.lru_out    = rd_lru;
endmodule

// File: tb/tb_cache_meta_array.sv
// Randomized bench for cache_meta_array against a set-level behavioural model.
module tb_cache_meta_array;
`ifdef CACHE_META_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  cache_meta_if bus ();
  cache_meta_array dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  // Model: per-set bits plus the number of busy cycles still to run.
  bit [1:0] m_valid [64];
  bit [1:0] m_dirty [64];
  bit       m_lru   [64];
  int       m_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      m_valid[s] = 2'b00;
      m_dirty[s] = 2'b00;
      m_lru[s]   = 1'b0;
    end
    m_busy = 0;
  endtask

  function automatic bit bad_oh();
    return (bus.upd_en | bus.touch_en) && ($countones(bus.set_oh) != 1);
  endfunction

  task automatic check_outputs();
    bit [1:0] ev = 2'b00;
    bit [1:0] ed = 2'b00;
    bit       el = 1'b0;
    for (int s = 0; s < 64; s++)
      if (bus.set_oh[s]) begin
        ev |= m_valid[s];
        ed |= m_dirty[s];
        el |= m_lru[s];
      end
    if (m_busy > 0) ev = 2'b00;
    check("valid_out",  64'(bus.valid_out),  64'(ev));
    check("dirty_out",  64'(bus.dirty_out),  64'(ed));
    check("lru_out",    64'(bus.lru_out),    64'(el));
    check("flush_busy", 64'(bus.flush_busy), 64'(m_busy > 0));
    check("flush_done", 64'(bus.flush_done), 64'(m_busy == 1));
    check("oh_err",     64'(bus.oh_err),     64'(CHK && rstn && bad_oh()));
  endtask

  task automatic model_edge();
    int idx;
    if (!rstn) begin
      model_reset();
    end else if (m_busy > 0) begin
      idx = 65 - m_busy;
      if (idx < 64) begin
        m_valid[idx] = 2'b00;
        m_dirty[idx] = 2'b00;
        m_lru[idx]   = 1'b0;
      end
      m_busy--;
    end else begin
      if (!(CHK && bad_oh()))
        for (int s = 0; s < 64; s++)
          if (bus.set_oh[s]) begin
            if (bus.upd_en) begin
              m_valid[s][bus.upd_way] = bus.upd_valid;
              m_dirty[s][bus.upd_way] = bus.upd_dirty;
            end
            if (bus.touch_en) m_lru[s] = ~bus.touch_way;
          end
      if (bus.flush_req) m_busy = 65;
    end
  endtask

  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    bus.set_oh = '0; bus.upd_en = 0; bus.upd_way = 0; bus.upd_valid = 0;
    bus.upd_dirty = 0; bus.touch_en = 0; bus.touch_way = 0; bus.flush_req = 0;
  endtask

  task automatic write_set(input int s, input bit way, input bit v, input bit d);
    idle_in();
    bus.set_oh = 64'd1 << s; bus.upd_en = 1; bus.upd_way = way;
    bus.upd_valid = v; bus.upd_dirty = d;
    tick();
    idle_in();
  endtask

  task automatic read_set(input int s, input string tag, input bit [1:0] ev, input bit [1:0] ed);
    idle_in();
    bus.set_oh = 64'd1 << s;
    #1;
    check({tag, "_valid"}, 64'(bus.valid_out), 64'(ev));
    check({tag, "_dirty"}, 64'(bus.dirty_out), 64'(ed));
    tick();
  endtask

  // Run until busy drops, counting busy cycles and done pulses; bounded.
  task automatic run_flush(output int busy_n, output int done_n, output int done_at);
    busy_n = 0; done_n = 0; done_at = 0;
    for (int k = 1; k <= 100; k++) begin
      if (bus.flush_done) begin done_n++; done_at = k; end
      if (!bus.flush_busy) break;
      busy_n++;
      tick();
    end
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    #1 rstn = 1'b1;
  endtask

  int busy_n, done_n, done_at, r;

  initial begin
    rstn = 1'b0;
    idle_in();
    model_reset();
    #1;
    check("rst_busy", 64'(bus.flush_busy), 64'd0);
    check("rst_done", 64'(bus.flush_done), 64'd0);
    tick();
    rstn = 1'b1;

    // Update then read
    write_set(5, 1'b1, 1'b1, 1'b1);
    read_set(5, "upd5", 2'b10, 2'b10);
    read_set(6, "upd6", 2'b00, 2'b00);

    // LRU
    idle_in(); bus.set_oh = 64'd1 << 9; bus.touch_en = 1; bus.touch_way = 0; tick();
    bus.touch_en = 0; #1 check("lru_t0", 64'(bus.lru_out), 64'd1); tick();
    bus.touch_en = 1; bus.touch_way = 1; tick();
    bus.touch_en = 0; #1 check("lru_t1", 64'(bus.lru_out), 64'd0); tick();

    // Flush of sets 0, 31, 63
    write_set(0, 1'b0, 1'b1, 1'b0);
    write_set(31, 1'b0, 1'b1, 1'b0);
    write_set(63, 1'b1, 1'b1, 1'b0);
    read_set(31, "pre_flush31", 2'b01, 2'b00);
    bus.flush_req = 1; tick(); bus.flush_req = 0;
    run_flush(busy_n, done_n, done_at);
    check("flush_busy_len", 64'(busy_n), 64'd65);
    check("flush_done_cnt", 64'(done_n), 64'd1);
    check("flush_done_at",  64'(done_at), 64'd65);
    read_set(0, "flushed0", 2'b00, 2'b00);
    read_set(31, "flushed31", 2'b00, 2'b00);
    read_set(63, "flushed63", 2'b00, 2'b00);

    // Update during flush is ignored
    bus.flush_req = 1; tick(); bus.flush_req = 0;
    for (int i = 1; i < 10; i++) tick();
    bus.set_oh = 64'd1 << 3; bus.upd_en = 1; bus.upd_valid = 1; bus.upd_dirty = 1; tick();
    idle_in();
    run_flush(busy_n, done_n, done_at);
    check("upd_in_flush_done", 64'(done_n), 64'd1);
    read_set(3, "upd_in_flush3", 2'b00, 2'b00);

    // Reset mid-flush
    write_set(40, 1'b0, 1'b1, 1'b1);
    write_set(40, 1'b1, 1'b1, 1'b1);
    bus.flush_req = 1; tick(); bus.flush_req = 0;
    for (int i = 1; i < 20; i++) tick();
    bus.set_oh = (64'd1 << 40) | 64'd1; bus.upd_en = 1;
    #2 rstn = 1'b0;
    model_reset();
    #1;
    check("midrst_busy",  64'(bus.flush_busy), 64'd0);
    check("midrst_done",  64'(bus.flush_done), 64'd0);
    check("midrst_valid", 64'(bus.valid_out),  64'd0);
    check("midrst_dirty", 64'(bus.dirty_out),  64'd0);
    check("midrst_oherr", 64'(bus.oh_err),     64'd0);
    idle_in();
    tick();
    rstn = 1'b1;
    write_set(2, 1'b0, 1'b1, 1'b0);
    read_set(2, "post_rst2", 2'b01, 2'b00);
    done_n = 0;
    for (int i = 0; i < 70; i++) begin
      if (bus.flush_done) done_n++;
      tick();
    end
    check("midrst_no_done", 64'(done_n), 64'd0);

    // Non-one-hot update
    idle_in();
    bus.set_oh = 64'h3; bus.upd_en = 1; bus.upd_valid = 1;
    #1 check("oh_err_dir", 64'(bus.oh_err), 64'(CHK));
    tick();
    read_set(0, "oh_set0", CHK ? 2'b00 : 2'b01, 2'b00);
    read_set(1, "oh_set1", CHK ? 2'b00 : 2'b01, 2'b00);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       bus.set_oh = 64'd1 << $urandom_range(0, 63);
      else if (r == 7) bus.set_oh = '0;
      else             bus.set_oh = {$urandom, $urandom};
      bus.upd_en    = 1'($urandom_range(0, 1));
      bus.upd_way   = 1'($urandom_range(0, 1));
      bus.upd_valid = 1'($urandom_range(0, 1));
      bus.upd_dirty = 1'($urandom_range(0, 1));
      bus.touch_en  = 1'($urandom_range(0, 1));
      bus.touch_way = 1'($urandom_range(0, 1));
      bus.flush_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 599) == 0) async_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
